// File: rtl/mem_port_arbiter.sv
// Two-requester shared memory port arbiter with bounded hold and handover.
// Ports: clk, rst_n (sync, low), REQ1/D1, REQ2/D2 in; GNT1, GNT2, S, Y, VALID out.
// Macro MEM_PORT_ARBITER_RR_EN selects round-robin idle tie-break.
module mem_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  input  logic             REQ2,
  input  logic [WIDTH-1:0] D2,
  output logic             GNT1,
  output logic             GNT2,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             VALID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  localparam logic [7:0] LIM = 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       last1;
  logic       tie1;

  // last1 = 1 when requester 1 was the most recent owner
`ifdef MEM_PORT_ARBITER_RR_EN
  assign tie1 = !last1;
`else
  assign tie1 = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (REQ1 && REQ2) state_nxt = tie1 ? OWN1 : OWN2;
        else if (REQ1)    state_nxt = OWN1;
        else if (REQ2)    state_nxt = OWN2;
        else              state_nxt = IDLE;
      end
      OWN1: begin
        if (!REQ1)
          state_nxt = REQ2 ? OWN2 : IDLE;
        else if (REQ2 && cnt == LIM)
          state_nxt = OWN2;
        else
          state_nxt = OWN1;
      end
      OWN2: begin
        if (!REQ2)
          state_nxt = REQ1 ? OWN1 : IDLE;
        else if (REQ1 && cnt == LIM)
          state_nxt = OWN1;
        else
          state_nxt = OWN2;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      last1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        cnt <= 8'd0;
      end else if (state_nxt != state) begin
        cnt   <= 8'd0;
        last1 <= (state_nxt == OWN1);
      end else if (cnt != LIM) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign GNT1  = (state == OWN1);
  assign GNT2  = (state == OWN2);
  assign S     = GNT1;
  assign VALID = GNT1 | GNT2;
  assign Y     = S ? D1 : D2;

endmodule
